// File: rtl/scoreboard_if.sv
// Shared record types and the decode/writeback/commit bundle of the scoreboard.
package scoreboard_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  trans_id;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;

endpackage

interface scoreboard_if;
  import scoreboard_pkg::*;

  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              decoded_instr_ack_o;
  logic [4:0]        trans_id_o;
  logic              full_o;

  logic              wb_valid_i;
  logic [4:0]        wb_trans_id_i;
  logic [63:0]       wb_data_i;
  exception_t        wb_ex_i;

  scoreboard_entry_t commit_instr_o;
  logic              commit_valid_o;
  logic              commit_ack_i;

  modport slave (
    input  decoded_instr_i, decoded_instr_valid_i,
    output decoded_instr_ack_o, trans_id_o, full_o,
    input  wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
    output commit_instr_o, commit_valid_o,
    input  commit_ack_i
  );

  modport master (
    output decoded_instr_i, decoded_instr_valid_i,
    input  decoded_instr_ack_o, trans_id_o, full_o,
    output wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
    input  commit_instr_o, commit_valid_o,
    output commit_ack_i
  );

endinterface

// File: rtl/scoreboard.sv
// In-order scoreboard: allocates entries at decode, collects out-of-order
// writebacks, forwards finished results to issue and retires in program order.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  scoreboard_if.slave sb,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rs1_fwd_valid_o,
  output logic        rs2_fwd_valid_o,
  output logic [63:0] rs1_fwd_o,
  output logic [63:0] rs2_fwd_o
);

  localparam int unsigned PW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  typedef struct packed {
    logic        busy;
    logic        fwd_valid;
    logic [63:0] data;
  } lookup_t;

  scoreboard_entry_t     mem_q [NR_ENTRIES];
  scoreboard_entry_t     mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] busy_q, busy_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]           cnt_q, cnt_d;

  logic          alloc, commit, wb_hit;
  logic [PW-1:0] wb_idx;
  lookup_t       lk1, lk2;

  assign sb.full_o              = (32'(cnt_q) == NR_ENTRIES);
  assign sb.decoded_instr_ack_o = sb.decoded_instr_valid_i && !sb.full_o && !flush_i;
  assign sb.trans_id_o          = 5'(tail_q);
  assign sb.commit_instr_o      = mem_q[head_q];
  assign sb.commit_valid_o      = (cnt_q != '0) && mem_q[head_q].valid;

  assign alloc  = sb.decoded_instr_ack_o;
  assign commit = sb.commit_ack_i && sb.commit_valid_o;
  assign wb_idx = sb.wb_trans_id_i[PW-1:0];
  assign wb_hit = sb.wb_valid_i && (32'(sb.wb_trans_id_i) < NR_ENTRIES) && busy_q[wb_idx];

  // Oldest-to-youngest scan so the last match wins, i.e. the youngest producer.
  function automatic lookup_t lookup(input logic [4:0] rs);
    lookup_t           r;
    logic              found;
    scoreboard_entry_t e;
    logic [PW-1:0]     idx;
    r     = '0;
    found = 1'b0;
    e     = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      idx = head_q + PW'(i);
      if ((i < 32'(cnt_q)) && busy_q[idx] && (mem_q[idx].rd == rs)) begin
        found = 1'b1;
        e     = mem_q[idx];
      end
    end
    if (found && (rs != '0)) begin
      if (e.ex.valid || !e.valid) begin
        r.busy = 1'b1;
      end else begin
        r.fwd_valid = 1'b1;
        r.data      = e.result;
      end
    end
    return r;
  endfunction

  always_comb begin
    lk1 = lookup(rs1_i);
    lk2 = lookup(rs2_i);
  end

  assign rs1_busy_o      = lk1.busy;
  assign rs1_fwd_valid_o = lk1.fwd_valid;
  assign rs1_fwd_o       = lk1.data;
  assign rs2_busy_o      = lk2.busy;
  assign rs2_fwd_valid_o = lk2.fwd_valid;
  assign rs2_fwd_o       = lk2.data;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      busy_d = '0;
    end else begin
      if (wb_hit) begin
        mem_d[wb_idx].result = sb.wb_data_i;
        mem_d[wb_idx].ex     = sb.wb_ex_i;
        mem_d[wb_idx].valid  = 1'b1;
      end
      // A decode exception needs no functional unit, so it is born finished.
      if (alloc) begin
        mem_d[tail_q]          = sb.decoded_instr_i;
        mem_d[tail_q].trans_id = 5'(tail_q);
        mem_d[tail_q].valid    = sb.decoded_instr_i.ex.valid;
        busy_d[tail_q]         = 1'b1;
        tail_d                 = tail_q + 1'b1;
      end
      if (commit) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      case ({alloc, commit})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the scoreboard.
module tb_scoreboard;
  import scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy, rs1_fv, rs2_fv;
  logic [63:0] rs1_fwd, rs2_fwd;

  int nassert = 0;
  int nfail   = 0;

  scoreboard_if sb_if ();

  scoreboard #(.NR_ENTRIES(8)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .sb              (sb_if.slave),
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .rs1_busy_o      (rs1_busy),
    .rs2_busy_o      (rs2_busy),
    .rs1_fwd_valid_o (rs1_fv),
    .rs2_fwd_valid_o (rs2_fv),
    .rs1_fwd_o       (rs1_fwd),
    .rs2_fwd_o       (rs2_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.wb_valid_i            = 1'b0;
    sb_if.commit_ack_i          = 1'b0;
    flush                       = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic wb(input int id, input logic [63:0] data);
    sb_if.wb_valid_i    = 1'b1;
    sb_if.wb_trans_id_i = 5'(id);
    sb_if.wb_data_i     = data;
    sb_if.wb_ex_i       = '0;
  endtask

  initial begin
    scoreboard_entry_t instr;
    rst_n = 1'b0;
    rs1 = '0;
    rs2 = '0;
    sb_if.decoded_instr_i = '0;
    sb_if.wb_trans_id_i   = '0;
    sb_if.wb_data_i       = '0;
    sb_if.wb_ex_i         = '0;
    idle();
    #12;
    chk("rst_ack", sb_if.decoded_instr_ack_o, 0);
    chk("rst_tid", sb_if.trans_id_o, 0);
    chk("rst_full", sb_if.full_o, 0);
    chk("rst_cvalid", sb_if.commit_valid_o, 0);
    chk("rst_busy", rs1_busy, 0);
    chk("rst_fv", rs1_fv, 0);
    chk("rst_fwd", rs1_fwd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill all eight entries with rd = 1..8, no writeback.
    for (int k = 0; k < 8; k++) begin
      instr = '0;
      instr.rd = 5'(k + 1);
      sb_if.decoded_instr_i = instr;
      sb_if.decoded_instr_valid_i = 1'b1;
      #1;
      chk("fill_tid", sb_if.trans_id_o, 64'(k));
      chk("fill_ack", sb_if.decoded_instr_ack_o, 1);
      tick();
    end
    #1;
    chk("full_set", sb_if.full_o, 1);
    chk("full_ack9", sb_if.decoded_instr_ack_o, 0);
    chk("full_cvalid", sb_if.commit_valid_o, 0);
    rs1 = 5'd3;
    rs2 = 5'd8;
    #1;
    chk("pend_rs1_busy", rs1_busy, 1);
    chk("pend_rs2_busy", rs2_busy, 1);
    chk("pend_rs1_fv", rs1_fv, 0);

    // Commit ack while nothing is finished must be ignored.
    idle();
    sb_if.commit_ack_i = 1'b1;
    tick();
    sb_if.commit_ack_i = 1'b0;
    #1;
    chk("bogus_ack_full", sb_if.full_o, 1);

    wb(3, 64'hA5);
    tick();
    wb(0, 64'h5A);
    #1;
    chk("wb_not_yet", sb_if.commit_valid_o, 0);
    tick();
    sb_if.wb_valid_i = 1'b0;
    rs1 = 5'd4;
    #1;
    chk("wb_cvalid", sb_if.commit_valid_o, 1);
    chk("wb_cres", sb_if.commit_instr_o.result, 64'h5A);
    chk("wb_ctid", sb_if.commit_instr_o.trans_id, 0);
    chk("fwd4_fv", rs1_fv, 1);
    chk("fwd4_data", rs1_fwd, 64'hA5);
    chk("fwd4_busy", rs1_busy, 0);

    // Full: allocation refused even with a simultaneous commit.
    sb_if.decoded_instr_valid_i = 1'b1;
    sb_if.commit_ack_i = 1'b1;
    #1;
    chk("full_commit_ack", sb_if.decoded_instr_ack_o, 0);
    tick();
    idle();
    #1;
    chk("pop_full", sb_if.full_o, 0);
    chk("pop_cvalid", sb_if.commit_valid_o, 0);
    chk("pop_tid", sb_if.trans_id_o, 0);
    chk("pop_head", sb_if.commit_instr_o.trans_id, 1);

    // Out-of-range id 9 aliases entry 1 in its low bits and must be ignored.
    wb(9, 64'hFF);
    tick();
    sb_if.wb_valid_i = 1'b0;
    #1;
    chk("wb_oor", sb_if.commit_valid_o, 0);

    // Flush beats alloc, writeback and commit in the same cycle.
    sb_if.decoded_instr_valid_i = 1'b1;
    wb(1, 64'h33);
    sb_if.commit_ack_i = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_ack", sb_if.decoded_instr_ack_o, 0);
    tick();
    idle();
    #1;
    chk("flush_full", sb_if.full_o, 0);
    chk("flush_cvalid", sb_if.commit_valid_o, 0);
    chk("flush_tid", sb_if.trans_id_o, 0);
    chk("flush_busy", rs1_busy, 0);
    chk("flush_fv", rs1_fv, 0);

    // Two producers of x5; only the youngest may forward.
    instr = '0;
    instr.rd = 5'd5;
    sb_if.decoded_instr_i = instr;
    sb_if.decoded_instr_valid_i = 1'b1;
    tick();
    tick();
    idle();
    wb(0, 64'h11);
    tick();
    sb_if.wb_valid_i = 1'b0;
    rs1 = 5'd5;
    rs2 = 5'd5;
    #1;
    chk("x5_old_busy", rs1_busy, 1);
    chk("x5_old_fv", rs1_fv, 0);
    chk("x5_rs2_busy", rs2_busy, 1);
    chk("x5_cvalid", sb_if.commit_valid_o, 1);
    wb(1, 64'h77);
    tick();
    sb_if.wb_valid_i = 1'b0;
    #1;
    chk("x5_new_fv", rs1_fv, 1);
    chk("x5_new_data", rs1_fwd, 64'h77);
    chk("x5_new_busy", rs1_busy, 0);
    chk("x5_rs2_data", rs2_fwd, 64'h77);
    rs1 = 5'd0;
    #1;
    chk("x0_busy", rs1_busy, 0);
    chk("x0_fv", rs1_fv, 0);
    do_flush();

    // Steady state: seven in flight, alloc + commit every cycle across wrap.
    instr = '0;
    instr.rd = 5'd9;
    sb_if.decoded_instr_i = instr;
    sb_if.decoded_instr_valid_i = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    idle();
    wb(0, 64'h100);
    tick();
    for (int c = 0; c < 20; c++) begin
      sb_if.decoded_instr_valid_i = 1'b1;
      sb_if.commit_ack_i = 1'b1;
      wb((c + 1) % 8, 64'h100 + 64'(c + 1));
      #1;
      chk("wrap_tid", sb_if.trans_id_o, 64'((c + 7) % 8));
      chk("wrap_ack", sb_if.decoded_instr_ack_o, 1);
      chk("wrap_cvalid", sb_if.commit_valid_o, 1);
      chk("wrap_cres", sb_if.commit_instr_o.result, 64'h100 + 64'(c));
      tick();
    end
    idle();
    #1;
    chk("wrap_full", sb_if.full_o, 0);
    chk("wrap_tid_end", sb_if.trans_id_o, 3);
    chk("wrap_head_tid", sb_if.commit_instr_o.trans_id, 4);
    chk("wrap_head_res", sb_if.commit_instr_o.result, 64'h114);
    do_flush();

    // Decode exception is finished on allocation and never forwarded.
    instr = '0;
    instr.rd = 5'd7;
    instr.ex.valid = 1'b1;
    instr.ex.cause = ILLEGAL_INSTR;
    sb_if.decoded_instr_i = instr;
    sb_if.decoded_instr_valid_i = 1'b1;
    tick();
    idle();
    rs1 = 5'd7;
    #1;
    chk("exc_cvalid", sb_if.commit_valid_o, 1);
    chk("exc_cause", sb_if.commit_instr_o.ex.cause, ILLEGAL_INSTR);
    chk("exc_busy", rs1_busy, 1);
    chk("exc_fv", rs1_fv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- In-order circular buffer of scoreboard_entry records between decode/issue and commit.
- Allocates one entry per decoded instruction and tags it with a trans_id.
- Captures out-of-order writebacks from the functional units, forwards finished results to issue, and presents the oldest entry to commit in program order.

Parameters:
NR_ENTRIES, 8, buffer depth; power of two, 2..32 (trans_id is 5 bits)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  discard all in-flight entries
decoded_instr_i  input  scoreboard_entry  instruction from decode
decoded_instr_valid_i  input  1  decode has an instruction
decoded_instr_ack_o  output  1  entry allocated this cycle
trans_id_o  output  5  index assigned to the allocated entry
full_o  output  1  no free entry
rs1_i  input  5  issue operand 1 register address
rs2_i  input  5  issue operand 2 register address
rs1_busy_o  output  1  in-flight producer of rs1 not finished
rs2_busy_o  output  1  in-flight producer of rs2 not finished
rs1_fwd_valid_o  output  1  rs1 value available from scoreboard
rs2_fwd_valid_o  output  1  rs2 value available from scoreboard
rs1_fwd_o  output  64  forwarded rs1 value
rs2_fwd_o  output  64  forwarded rs2 value
wb_valid_i  input  1  functional unit writeback
wb_trans_id_i  input  5  entry being written back
wb_data_i  input  64  result
wb_ex_i  input  exception  exception raised by the functional unit
commit_instr_o  output  scoreboard_entry  oldest entry
commit_valid_o  output  1  oldest entry finished
commit_ack_i  input  1  commit consumes the oldest entry

Behaviour:
- State: entry array, head/tail pointers (log2 NR_ENTRIES bits, wrap modulo NR_ENTRIES), count (0..NR_ENTRIES), per-entry busy bit.
- Reset (async) and flush_i (sync): pointers=0, count=0, all busy=0. Flush has priority over alloc, writeback and commit in the same cycle.
- Reset values: ack=0, trans_id_o=0, full_o=0, commit_valid_o=0, all busy/fwd_valid=0, fwd data=0.
- full_o = (count==NR_ENTRIES).
- Allocation:
  - decoded_instr_ack_o = decoded_instr_valid_i && !full_o && !flush_i (combinational).
  - trans_id_o = tail (combinational).
  - On ack: entry[tail] = decoded_instr_i with trans_id=tail; valid = decoded_instr_i.ex.valid (a decode exception is already finished). Set busy; tail+1.
  - When full, allocation is refused even if commit_ack_i is asserted the same cycle.
- Writeback:
  - Applies when wb_valid_i and busy[wb_trans_id_i]: result=wb_data_i, ex=wb_ex_i, valid=1.
  - Writeback to a non-busy index or to an index >= NR_ENTRIES is ignored.
  - Visible at the outputs one cycle later.
- Commit:
  - commit_instr_o = entry[head] (registered state).
  - commit_valid_o = count!=0 && entry[head].valid.
  - commit_ack_i with commit_valid_o=0 is ignored.
  - On a valid ack: busy[head]=0, head+1.
  - Allocate and commit in the same cycle leave count unchanged.
- Lookup (combinational, registered state only; same-cycle writeback/allocation not seen):
  - Find the youngest busy entry with rd==rsX, scanning from tail-1 back to head.
  - If none, or rsX==0: busy=0, fwd_valid=0, data=0.
  - If found and valid=1: fwd_valid=1, data=result, busy=0.
  - If found and valid=0: busy=1, fwd_valid=0.
  - If the youngest match has ex.valid: busy=1, fwd_valid=0 (never forward an excepting result).
- Latency: allocation to commit_valid_o is at least 1 cycle after the writeback cycle.

Test Plan:
- Reset, then allocate 8 entries with rd=1..8 without writeback -> trans_id_o 0..7, full_o=1 after the 8th, 9th valid gets ack=0; commit_valid_o=0.
- Writeback trans_id 3 then 0 with data 0xA5, 0x5A -> commit_valid_o=1 next cycle, commit ack pops entry 0 (result 0x5A); entry 1 is still pending so commit_valid_o=0.
- Two entries with rd=5 (ids 0,1), writeback id 0 only -> rs1_i=5 gives busy=1, fwd_valid=0; after writeback id 1 with 0x77 -> fwd_valid=1, data 0x77. rs1_i=0 is always busy=0.
- Fill, commit and allocate in the same cycle over 20 cycles -> pointers wrap, trans_id_o cycles 0..7, count stable, no lost entries.
- Flush asserted with simultaneous alloc, writeback and commit_ack -> next cycle count=0, full_o=0, commit_valid_o=0, ack=0 during flush.
- Decode entry with ex.valid=1 cause ILLEGAL_INSTR -> commit_valid_o=1 next cycle without writeback; rd lookup gives busy=1.
